// File: rtl/wb_arbiter_pkg.sv
// Shared defaults and the result-entry layout for the writeback arbiter.
// A buffered entry is packed as {rd, data} with rd in the upper bits.
package wb_arbiter_pkg;

    localparam int DATA_W_DEF       = 32;
    localparam int REG_W_DEF        = 5;
    localparam int FIFO_DEPTH_DEF   = 2;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef struct packed {
        logic [REG_W_DEF-1:0]  rd;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for mult/div results. Push and pop may occur in the
// same cycle, including when full; occupancy is the single source of full/empty.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with buffered mult/div
// results into one registered register-file write stream, with a starvation guard.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int REG_W        = REG_W_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1,
    localparam int STARVE_W    = $clog2(STARVE_LIMIT) + 1,
    localparam int ENTRY_W     = REG_W + DATA_W
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_W-1:0]  md_rd,
    input  logic [DATA_W-1:0] md_data,
    output logic              alu_stall,
    output logic              ctrl_writeEnable,
    output logic [REG_W-1:0]  ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic [CNT_W-1:0]  md_count
);

    logic [ENTRY_W-1:0]  head;
    logic [REG_W-1:0]    head_rd;
    logic [DATA_W-1:0]   head_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic                alu_sel;
    logic                pop;
    logic                push;
    logic                starve_fire;

    logic                we_q, we_d;
    logic [REG_W-1:0]    wreg_q, wreg_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                stall_q, stall_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (ctrl_reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({md_rd, md_data}),
        .rdata_o (head),
        .count_o (md_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_rd   = head[ENTRY_W-1 -: REG_W];
    assign head_data = head[DATA_W-1:0];

    assign alu_sel  = alu_valid & ~stall_q;
    assign pop      = ~alu_sel & ~fifo_empty;
    assign md_ready = ~fifo_full | pop;
    assign push     = md_valid & md_ready;

    // Fires on the STARVE_LIMIT-th consecutive unserved cycle; the following
    // stall cycle is guaranteed a pop, so the pulse can never repeat back-to-back.
    assign starve_fire = ~fifo_empty & ~pop & (starve_q == STARVE_W'(STARVE_LIMIT - 1));

    always_comb begin
        we_d     = 1'b0;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        stall_d  = starve_fire;
        starve_d = starve_q + STARVE_W'(1);
        if (fifo_empty || pop || starve_fire) starve_d = '0;

        if (alu_sel) begin
            we_d    = (alu_rd != '0);
            wreg_d  = alu_rd;
            wdata_d = alu_data;
        end else if (pop) begin
            we_d    = (head_rd != '0);
            wreg_d  = head_rd;
            wdata_d = head_data;
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            stall_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            stall_q  <= stall_d;
            starve_q <= starve_d;
        end
    end

    assign alu_stall        = stall_q;
    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;

endmodule
